// File: rtl/i2c_register_bank_pkg.sv
// Shared widths, register addresses and constants for the I2C-facing register bank.
package i2c_register_bank_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 6;

    localparam logic [REG_ADDR_W-1:0] ADDR_VERSION   = 6'h00;
    localparam logic [REG_ADDR_W-1:0] ADDR_CONTROL   = 6'h01;
    localparam logic [REG_ADDR_W-1:0] ADDR_STATUS    = 6'h02;
    localparam logic [REG_ADDR_W-1:0] ADDR_EVENT     = 6'h03;
    localparam logic [REG_ADDR_W-1:0] ADDR_IRQ_MASK  = 6'h04;
    localparam logic [REG_ADDR_W-1:0] ADDR_SCRATCH   = 6'h05;
    localparam logic [REG_ADDR_W-1:0] ADDR_TIMESTAMP = 6'h06;

    localparam logic [REG_DATA_W-1:0] UNMAPPED_READ = 32'h0000_0000;

    // True when a strobe targets the given register this cycle.
    function automatic logic strobe_hit(input logic strobe,
                                        input logic [REG_ADDR_W-1:0] addr,
                                        input logic [REG_ADDR_W-1:0] target);
        return strobe && (addr == target);
    endfunction

endpackage

// File: rtl/i2c_register_bank_status_sync_edge.sv
// Two-flop synchronizer per bit plus a third flop that exposes synchronized rising edges.
module status_sync_edge #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain and edge-history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/i2c_register_bank.sv
// MCU-visible register file behind the I2C slave: control, status, sticky events, IRQ and timestamp.
module i2c_register_bank
    import i2c_register_bank_pkg::*;
#(
    parameter logic [REG_DATA_W-1:0] FPGA_VERSION  = 32'h0001_0000,
    parameter logic [REG_DATA_W-1:0] CONTROL_RESET = 32'h0000_0000,
    parameter int                    TS_PRESCALE   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] register_address,
    input  logic [REG_DATA_W-1:0] data_to_register,
    input  logic                  data_to_register_wr,
    output logic [REG_DATA_W-1:0] data_from_register,
    input  logic                  data_from_register_rd,
    input  logic [REG_DATA_W-1:0] status_in,
    output logic [REG_DATA_W-1:0] control_out,
    output logic                  irq_out
);

    localparam int PRESC_W = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TS_PRESCALE - 1);

    logic [REG_DATA_W-1:0] control_q, control_d;
    logic [REG_DATA_W-1:0] mask_q, mask_d;
    logic [REG_DATA_W-1:0] scratch_q, scratch_d;
    logic [REG_DATA_W-1:0] event_q, event_d;
    logic [REG_DATA_W-1:0] ts_q, ts_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [REG_DATA_W-1:0] dout_q, dout_d;
    logic                  irq_q, irq_d;

    logic [REG_DATA_W-1:0] status_sync_s;
    logic [REG_DATA_W-1:0] status_rise_s;
    logic [REG_DATA_W-1:0] event_clr_s;

    status_sync_edge #(.WIDTH(REG_DATA_W)) u_status_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (status_in),
        .sync_o  (status_sync_s),
        .rise_o  (status_rise_s)
    );

    // Read mux, sampled every cycle so data is ready one clock after an address change.
    always_comb begin
        dout_d = UNMAPPED_READ;
        case (register_address)
            ADDR_VERSION:   dout_d = FPGA_VERSION;
            ADDR_CONTROL:   dout_d = control_q;
            ADDR_STATUS:    dout_d = status_sync_s;
            ADDR_EVENT:     dout_d = event_q;
            ADDR_IRQ_MASK:  dout_d = mask_q;
            ADDR_SCRATCH:   dout_d = scratch_q;
            ADDR_TIMESTAMP: dout_d = ts_q;
            default:        dout_d = UNMAPPED_READ;
        endcase
    end

    // Plain RW registers take write data when addressed.
    always_comb begin
        control_d = control_q;
        mask_d    = mask_q;
        scratch_d = scratch_q;
        if (strobe_hit(data_to_register_wr, register_address, ADDR_CONTROL)) begin
            control_d = data_to_register;
        end else begin
            control_d = control_q;
        end
        if (strobe_hit(data_to_register_wr, register_address, ADDR_IRQ_MASK)) begin
            mask_d = data_to_register;
        end else begin
            mask_d = mask_q;
        end
        if (strobe_hit(data_to_register_wr, register_address, ADDR_SCRATCH)) begin
            scratch_d = data_to_register;
        end else begin
            scratch_d = scratch_q;
        end
    end

    // Read-clear only drops the bits the MCU actually saw, so new edges are never lost; set beats clear.
    always_comb begin
        event_clr_s = '0;
        if (strobe_hit(data_from_register_rd, register_address, ADDR_EVENT)) begin
            event_clr_s = event_clr_s | dout_q;
        end else begin
            event_clr_s = event_clr_s;
        end
        if (strobe_hit(data_to_register_wr, register_address, ADDR_EVENT)) begin
            event_clr_s = event_clr_s | data_to_register;
        end else begin
            event_clr_s = event_clr_s;
        end
        event_d = (event_q & ~event_clr_s) | status_rise_s;
        irq_d   = |(event_q & mask_q);
    end

    // Timestamp prescaler; a write reloads the counter and restarts the prescale period.
    always_comb begin
        ts_d    = ts_q;
        presc_d = presc_q;
        if (strobe_hit(data_to_register_wr, register_address, ADDR_TIMESTAMP)) begin
            ts_d    = data_to_register;
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            ts_d    = ts_q + 32'd1;
            presc_d = '0;
        end else begin
            ts_d    = ts_q;
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control_q <= CONTROL_RESET;
            mask_q    <= '0;
            scratch_q <= '0;
            event_q   <= '0;
            ts_q      <= '0;
            presc_q   <= '0;
            dout_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            control_q <= control_d;
            mask_q    <= mask_d;
            scratch_q <= scratch_d;
            event_q   <= event_d;
            ts_q      <= ts_d;
            presc_q   <= presc_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
        end
    end

    assign data_from_register = dout_q;
    assign control_out        = control_q;
    assign irq_out            = irq_q;

endmodule
